ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage: one stage register feeding a combinational ALU / address unit.
// Optional iterative multiplier enabled by defining EX_STAGE_MUL_EN.
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [5:0]        aluop,
  input  logic [DATA_W-1:0] reg_1,
  input  logic [DATA_W-1:0] reg_2,
  input  logic [4:0]        write_reg,
  input  logic              we,
  input  logic [31:0]       id_inst,
  input  logic [DATA_W-1:0] link_addr,
  output logic              exe_we,
  output logic [4:0]        exe_write_reg,
  output logic [DATA_W-1:0] exe_write_data,
  output logic              last_is_load,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [5:0]        mem_aluop,
  output logic              stall_req
);

  localparam logic [5:0] EXE_NOP_OP  = 6'd0;
  localparam logic [5:0] EXE_AND_OP  = 6'd1;
  localparam logic [5:0] EXE_OR_OP   = 6'd2;
  localparam logic [5:0] EXE_XOR_OP  = 6'd3;
  localparam logic [5:0] EXE_NOR_OP  = 6'd4;
  localparam logic [5:0] EXE_ADD_OP  = 6'd5;
  localparam logic [5:0] EXE_SUB_OP  = 6'd6;
  localparam logic [5:0] EXE_SLT_OP  = 6'd7;
  localparam logic [5:0] EXE_SLTU_OP = 6'd8;
  localparam logic [5:0] EXE_SLL_OP  = 6'd9;
  localparam logic [5:0] EXE_SRL_OP  = 6'd10;
  localparam logic [5:0] EXE_SRA_OP  = 6'd11;
  localparam logic [5:0] EXE_JAL_OP  = 6'd12;
  localparam logic [5:0] EXE_LB_OP   = 6'd13;
  localparam logic [5:0] EXE_LW_OP   = 6'd14;
  localparam logic [5:0] EXE_SB_OP   = 6'd15;
  localparam logic [5:0] EXE_SW_OP   = 6'd16;
  localparam logic [5:0] EXE_MUL_OP  = 6'd17;

  logic [5:0]        aluop_p0;
  logic [DATA_W-1:0] r1_p0;
  logic [DATA_W-1:0] r2_p0;
  logic [4:0]        wreg_p0;
  logic              we_p0;
  logic [31:0]       inst_p0;
  logic [DATA_W-1:0] link_p0;
  logic              load_en;

  assign load_en = !stall && !stall_req;

  // ---- stage register: ID -> EX (bubble on reset/flush, hold on any stall)
  always_ff @(posedge clk) begin
    if (rst || (load_en && flush)) begin
      aluop_p0 <= EXE_NOP_OP;
      r1_p0    <= '0;
      r2_p0    <= '0;
      wreg_p0  <= '0;
      we_p0    <= 1'b0;
      inst_p0  <= '0;
      link_p0  <= '0;
    end else if (load_en) begin
      aluop_p0 <= aluop;
      r1_p0    <= reg_1;
      r2_p0    <= reg_2;
      wreg_p0  <= write_reg;
      we_p0    <= we;
      inst_p0  <= id_inst;
      link_p0  <= link_addr;
    end
  end

`ifdef EX_STAGE_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t        state, state_next;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic              mul_start;

  // The multiply starts on the same edge the MUL is latched into the stage.
  assign mul_start = load_en && !flush && (aluop == EXE_MUL_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state == BUSY) ? cnt + 5'd1 : 5'd0;
    end
  end

  always_comb begin
    state_next = state;
    stall_req  = 1'b0;
    case (state)
      IDLE: if (mul_start) state_next = BUSY;
      BUSY: begin
        stall_req = 1'b1;
        if (cnt == 5'd31) state_next = DONE;
      end
      DONE: state_next = mul_start ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift-add datapath; only the low DATA_W bits of the product are kept.
  always_ff @(posedge clk) begin
    if (mul_start) begin
      acc    <= '0;
      mcand  <= reg_1;
      mplier <= reg_2;
    end else if (state == BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign stall_req = 1'b0;
`endif

  logic signed [DATA_W-1:0] r1_s;
  logic signed [DATA_W-1:0] r2_s;
  logic [4:0]               shamt;
  logic [DATA_W-1:0]        eff_addr;
  logic [DATA_W-1:0]        result;
  logic                     listed;

  assign r1_s     = r1_p0;
  assign r2_s     = r2_p0;
  assign shamt    = r1_p0[4:0];
  assign eff_addr = r1_p0 + {{(DATA_W-16){inst_p0[15]}}, inst_p0[15:0]};

  // ---- execute: combinational from the stage register
  always_comb begin
    result       = '0;
    listed       = 1'b1;
    mem_addr     = '0;
    mem_wdata    = '0;
    last_is_load = 1'b0;
    case (aluop_p0)
      EXE_ADD_OP:  result = r1_p0 + r2_p0;
      EXE_SUB_OP:  result = r1_p0 - r2_p0;
      EXE_AND_OP:  result = r1_p0 & r2_p0;
      EXE_OR_OP:   result = r1_p0 | r2_p0;
      EXE_XOR_OP:  result = r1_p0 ^ r2_p0;
      EXE_NOR_OP:  result = ~(r1_p0 | r2_p0);
      EXE_SLT_OP:  result = {{(DATA_W-1){1'b0}}, (r1_s < r2_s)};
      EXE_SLTU_OP: result = {{(DATA_W-1){1'b0}}, (r1_p0 < r2_p0)};
      EXE_SLL_OP:  result = r2_p0 << shamt;
      EXE_SRL_OP:  result = r2_p0 >> shamt;
      EXE_SRA_OP:  result = r2_s >>> shamt;
      EXE_JAL_OP:  result = link_p0;
      EXE_LB_OP, EXE_LW_OP: begin
        mem_addr     = eff_addr;
        last_is_load = 1'b1;
      end
      EXE_SB_OP, EXE_SW_OP: begin
        mem_addr  = eff_addr;
        mem_wdata = r2_p0;
      end
`ifdef EX_STAGE_MUL_EN
      EXE_MUL_OP:  result = (state == DONE) ? acc : '0;
`endif
      default:     listed = 1'b0;
    endcase
  end

  assign exe_write_data = result;
  assign exe_we         = we_p0 && listed && !stall_req;
  assign exe_write_reg  = wreg_p0;
  assign mem_aluop      = aluop_p0;

endmodule
